// File: rtl/riscv_loader_pkg.sv
// Shared definitions for the hex program loader: FSM state encoding and the
// ASCII characters the loader treats specially.
package riscv_loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRecv  = 3'd1,
        StWrite = 3'd2,
        StDone  = 3'd3,
        StError = 3'd4
    } state_e;

    localparam logic [7:0] CH_DOT = 8'h2E;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;

endpackage

// File: rtl/hex_program_loader_if.sv
// Character stream in, word-write bus and load status out.
// Carries the checksum signal only when HEX_LOADER_CHECKSUM_EN is defined.
interface hex_program_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;
`ifdef HEX_LOADER_CHECKSUM_EN
    logic [31:0] checksum;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata, load_busy, load_done, load_error,
               word_count, checksum
    );
    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata, load_busy, load_done, load_error,
               word_count, checksum
    );
`else
    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata, load_busy, load_done, load_error,
               word_count
    );
    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata, load_busy, load_done, load_error,
               word_count
    );
`endif
endinterface

// File: rtl/ascii_hex_decode.sv
// Combinational classifier for one ASCII character: hex digit (with value),
// whitespace, or end marker.
module ascii_hex_decode
    import riscv_loader_pkg::*;
(
    input  logic [7:0] rx_data_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o,
    output logic       is_ws_o,
    output logic       is_end_o
);

    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
            is_hex_o = 1'b1;
            nibble_o = rx_data_i[3:0];
        end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                     (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            is_hex_o = 1'b1;
            nibble_o = rx_data_i[3:0] + 4'd9;
        end
        is_ws_o  = (rx_data_i == CH_SP) || (rx_data_i == CH_TAB) ||
                   (rx_data_i == CH_LF) || (rx_data_i == CH_CR);
        is_end_o = (rx_data_i == CH_DOT);
    end

endmodule

// File: rtl/hex_program_loader.sv
// Assembles 8-digit ASCII hex groups into 32-bit words and writes them to
// consecutive word addresses. Optional HEX_LOADER_CHECKSUM_EN adds a running sum.
module hex_program_loader
    import riscv_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input logic                 clk,
    input logic                 rst,
    hex_program_loader_if.slave bus_io
);

    localparam logic [15:0] MaxWordsW = 16'(MAX_WORDS);

    state_e      state_q;
    logic [27:0] shift_q;
    logic [2:0]  digit_cnt_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] word_count_q;
`ifdef HEX_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;
`endif

    logic        is_hex;
    logic        is_ws;
    logic        is_end;
    logic [3:0]  nibble;
    logic        char_fault;
    logic        char_finish;

    ascii_hex_decode u_decode (
        .rx_data_i (bus_io.rx_data),
        .is_hex_o  (is_hex),
        .nibble_o  (nibble),
        .is_ws_o   (is_ws),
        .is_end_o  (is_end)
    );

    // Classify the offered character against the current word position.
    always_comb begin
        char_finish = is_end && (digit_cnt_q == 3'd0);
        if (is_hex) begin
            char_fault = (word_count_q == MaxWordsW);
        end else if (is_ws || is_end) begin
            char_fault = (digit_cnt_q != 3'd0);
        end else begin
            char_fault = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            digit_cnt_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
`ifdef HEX_LOADER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            if (bus_io.start) begin
                // A write already strobing this cycle completes; the new load
                // simply starts over from the base address.
                state_q      <= StRecv;
                shift_q      <= '0;
                digit_cnt_q  <= '0;
                mem_addr_q   <= BASE_ADDR;
                done_q       <= 1'b0;
                error_q      <= 1'b0;
                word_count_q <= '0;
`ifdef HEX_LOADER_CHECKSUM_EN
                checksum_q   <= '0;
`endif
            end else begin
                case (state_q)
                    StRecv: begin
                        if (bus_io.rx_valid) begin
                            if (char_fault) begin
                                state_q <= StError;
                                error_q <= 1'b1;
                            end else if (char_finish) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else if (is_hex) begin
                                if (digit_cnt_q == 3'd7) begin
                                    mem_wdata_q <= {shift_q, nibble};
                                    mem_we_q    <= 1'b1;
                                    digit_cnt_q <= '0;
                                    state_q     <= StWrite;
                                end else begin
                                    shift_q     <= {shift_q[23:0], nibble};
                                    digit_cnt_q <= digit_cnt_q + 3'd1;
                                end
                            end
                        end
                    end
                    StWrite: begin
                        mem_addr_q   <= mem_addr_q + 32'd4;
                        word_count_q <= word_count_q + 16'd1;
`ifdef HEX_LOADER_CHECKSUM_EN
                        checksum_q   <= checksum_q + mem_wdata_q;
`endif
                        state_q      <= StRecv;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus_io.rx_ready   = (state_q == StRecv);
    assign bus_io.load_busy  = (state_q == StRecv) || (state_q == StWrite);
    assign bus_io.mem_we     = mem_we_q;
    assign bus_io.mem_addr   = mem_addr_q;
    assign bus_io.mem_wdata  = mem_wdata_q;
    assign bus_io.load_done  = done_q;
    assign bus_io.load_error = error_q;
    assign bus_io.word_count = word_count_q;
`ifdef HEX_LOADER_CHECKSUM_EN
    assign bus_io.checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_hex_program_loader.sv
// Self-checking bench: a default loader and a MAX_WORDS=2 loader share one
// character stream; results are compared to a string-parsing reference model.
module tb_hex_program_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_program_loader_if ifm ();
    hex_program_loader_if ifs ();

    assign ifs.start    = ifm.start;
    assign ifs.rx_valid = ifm.rx_valid;
    assign ifs.rx_data  = ifm.rx_data;

    hex_program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (ifm)
    );

    hex_program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(2)) u_dut_small (
        .clk    (clk),
        .rst    (rst),
        .bus_io (ifs)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Write monitor, sampled mid-cycle
    logic [63:0] got_m[$];
    logic [63:0] got_s[$];
    int          we_viol = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (ifm.mem_we) begin
            got_m.push_back({ifm.mem_addr, ifm.mem_wdata});
            if (prev_we || ifm.rx_ready || !ifm.load_busy) we_viol <= we_viol + 1;
        end
        if (ifs.mem_we) got_s.push_back({ifs.mem_addr, ifs.mem_wdata});
        prev_we <= ifm.mem_we;
    end

    // Reference model: parse the text by the loader's rules.
    logic [31:0] mdl_words[$];
    int          mdl_status;  // 0 still loading, 1 done, 2 error
    int          mdl_used;

    logic [31:0] exp_m[$];
    logic [31:0] exp_s[$];
    int          st_m, st_s, used_m;

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - int'(8'h30);
        if (c >= "a" && c <= "f") return int'(c) - int'(8'h61) + 10;
        if (c >= "A" && c <= "F") return int'(c) - int'(8'h41) + 10;
        return -1;
    endfunction

    task automatic run_model(input string s, input int maxw);
        int          digits;
        logic [31:0] acc;
        logic [7:0]  c;
        int          v;
        digits = 0;
        acc    = '0;
        mdl_words.delete();
        mdl_status = 0;
        mdl_used   = s.len();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            v = hexval(c);
            if (v >= 0) begin
                if (mdl_words.size() == maxw) begin
                    mdl_status = 2; mdl_used = i + 1; return;
                end
                acc = (acc << 4) | 32'(v);
                digits++;
                if (digits == 8) begin
                    mdl_words.push_back(acc);
                    digits = 0;
                    acc = '0;
                end
            end else if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D) begin
                if (digits != 0) begin
                    mdl_status = 2; mdl_used = i + 1; return;
                end
            end else if (c == 8'h2E) begin
                mdl_status = (digits == 0) ? 1 : 2;
                mdl_used   = i + 1;
                return;
            end else begin
                mdl_status = 2; mdl_used = i + 1; return;
            end
        end
    endtask

    task automatic pulse_start();
        ifm.start = 1'b1;
        @(posedge clk); #1;
        ifm.start = 1'b0;
    endtask

    task automatic send_stream(input string s, input int n, input bit gaps);
        int k;
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                ifm.rx_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            ifm.rx_valid = 1'b1;
            ifm.rx_data  = s[i];
            k  = 0;
            ok = 1'b0;
            while (!ok && k < 50) begin
                @(negedge clk);
                if (ifm.rx_ready) begin
                    @(posedge clk); #1;
                    ok = 1'b1;
                end
                k++;
            end
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL handshake_timeout: char %0d not accepted within 50 cycles", i);
                ifm.rx_valid = 1'b0;
                return;
            end
        end
        ifm.rx_valid = 1'b0;
    endtask

    // Model both loaders, restart the load, stream, and let the last write settle.
    task automatic play(input string s, input bit gaps);
        run_model(s, 256);
        exp_m = mdl_words; st_m = mdl_status; used_m = mdl_used;
        run_model(s, 2);
        exp_s = mdl_words; st_s = mdl_status;
        got_m.delete(); got_s.delete();
        we_viol = 0;
        pulse_start();
        send_stream(s, used_m, gaps);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifm.start = 1'b0; ifm.rx_valid = 1'b0; ifm.rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ifm.rx_ready, ifm.mem_we, ifm.load_busy, ifm.load_done, ifm.load_error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000",
                     {ifm.rx_ready, ifm.mem_we, ifm.load_busy, ifm.load_done, ifm.load_error});
        end
        n_checks++;
        if ({ifm.mem_addr, ifm.mem_wdata, ifm.word_count} !== 80'h0) begin
            n_fail++;
            $display("FAIL reset_regs: addr %h data %h count %0d required all zero",
                     ifm.mem_addr, ifm.mem_wdata, ifm.word_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ifm.rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_not_ready: rx_ready %b required 0", ifm.rx_ready);
        end
    endtask

    task automatic test_single();
        play("00500093\n.", 1'b0);
        n_checks++;
        if (got_m.size() !== 1 || got_m[0] !== {32'h0, 32'h00500093}) begin
            n_fail++;
            $display("FAIL single_write: got %0d writes (first %h) required 1 write %h",
                     got_m.size(), (got_m.size() > 0) ? got_m[0] : 64'h0, {32'h0, 32'h00500093});
        end
        n_checks++;
        if ({ifm.load_done, ifm.load_error, ifm.load_busy} !== 3'b100 || ifm.word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_status: done/err/busy %b count %0d required 100 count 1",
                     {ifm.load_done, ifm.load_error, ifm.load_busy}, ifm.word_count);
        end
    endtask

    task automatic test_back_to_back();
        play($sformatf("00A00113 00B00193%c%c00c00213.", 8'h0D, 8'h0A), 1'b0);
        n_checks++;
        if (exp_m.size() !== 3 || exp_m[2] !== 32'h00C00213 || st_m !== 1) begin
            n_fail++;
            $display("FAIL b2b_model: model gave %0d words status %0d required 3 words done",
                     exp_m.size(), st_m);
        end
        n_checks++;
        if (got_m.size() !== exp_m.size()) begin
            n_fail++;
            $display("FAIL b2b_nwrites: got %0d required %0d", got_m.size(), exp_m.size());
        end
        for (int i = 0; i < exp_m.size() && i < got_m.size(); i++) begin
            n_checks++;
            if (got_m[i] !== {32'(4 * i), exp_m[i]}) begin
                n_fail++;
                $display("FAIL b2b_write%0d: got %h required %h", i, got_m[i], {32'(4 * i), exp_m[i]});
            end
        end
        n_checks++;
        if (we_viol !== 0 || ifm.word_count !== 16'd3 || ifm.load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_status: strobe violations %0d count %0d done %b required 0 3 1",
                     we_viol, ifm.word_count, ifm.load_done);
        end
    endtask

    task automatic test_truncated();
        bit saw_ready;
        play("0050 0093", 1'b0);
        n_checks++;
        if (ifm.load_error !== 1'b1 || ifm.load_done !== 1'b0 || got_m.size() !== 0) begin
            n_fail++;
            $display("FAIL trunc_status: err %b done %b writes %0d required 1 0 0",
                     ifm.load_error, ifm.load_done, got_m.size());
        end
        saw_ready = 1'b0;
        ifm.rx_valid = 1'b1;
        ifm.rx_data  = "0";
        repeat (6) begin
            @(negedge clk);
            if (ifm.rx_ready) saw_ready = 1'b1;
        end
        ifm.rx_valid = 1'b0;
        #1;
        n_checks++;
        if (saw_ready !== 1'b0 || got_m.size() !== 0 || ifm.word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL trunc_stuck: ready seen %b writes %0d count %0d required 0 0 0",
                     saw_ready, got_m.size(), ifm.word_count);
        end
    endtask

    task automatic test_overflow();
        play("00000001 00000002\n00000003 .", 1'b1);
        n_checks++;
        if (got_s.size() !== 2 || ifs.load_error !== 1'b1 || ifs.word_count !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow_small: writes %0d err %b count %0d required 2 1 2",
                     got_s.size(), ifs.load_error, ifs.word_count);
        end
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            n_checks++;
            if (got_s[i] !== {32'(4 * i), exp_s[i]}) begin
                n_fail++;
                $display("FAIL overflow_write%0d: got %h required %h", i, got_s[i],
                         {32'(4 * i), exp_s[i]});
            end
        end
        n_checks++;
        if (got_m.size() !== 3 || ifm.load_done !== 1'b1 || ifm.load_error !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_main: writes %0d done %b err %b required 3 1 0",
                     got_m.size(), ifm.load_done, ifm.load_error);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_stream("11111111 12345", 14, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ifm.rx_ready, ifm.mem_we, ifm.load_busy, ifm.load_done, ifm.load_error} !== 5'b0 ||
            {ifm.mem_addr, ifm.mem_wdata, ifm.word_count} !== 80'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: flags %b addr %h data %h count %0d required all zero",
                     {ifm.rx_ready, ifm.mem_we, ifm.load_busy, ifm.load_done, ifm.load_error},
                     ifm.mem_addr, ifm.mem_wdata, ifm.word_count);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        play("DEADBEEF.", 1'b0);
        n_checks++;
        if (got_m.size() !== 1 || got_m[0] !== {32'h0, 32'hDEADBEEF} || ifm.load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_reload: %0d writes first %h done %b required 1 write %h done 1",
                     got_m.size(), (got_m.size() > 0) ? got_m[0] : 64'h0,
                     {32'h0, 32'hDEADBEEF}, ifm.load_done);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        send_stream("ABCD", 4, 1'b0);
        play("12345678.", 1'b0);
        n_checks++;
        if (got_m.size() !== 1 || got_m[0] !== {32'h0, 32'h12345678} || ifm.word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL restart_write: %0d writes first %h count %0d required 1 write %h",
                     got_m.size(), (got_m.size() > 0) ? got_m[0] : 64'h0, ifm.word_count,
                     {32'h0, 32'h12345678});
        end
    endtask

    function automatic string rand_stream();
        string      s;
        logic [7:0] ch;
        logic [7:0] ws[4];
        int         v;
        ws[0] = 8'h20; ws[1] = 8'h09; ws[2] = 8'h0A; ws[3] = 8'h0D;
        s = "";
        for (int w = 0; w < $urandom_range(1, 4); w++) begin
            for (int d = 0; d < 8; d++) begin
                v = $urandom_range(0, 15);
                if (v < 10) ch = 8'h30 + 8'(v);
                else ch = ($urandom_range(0, 1) ? 8'h61 : 8'h41) + 8'(v - 10);
                if ($urandom_range(0, 40) == 0) ch = "g";
                if ($urandom_range(0, 40) != 0) s = $sformatf("%s%c", s, ch);
            end
            for (int k = 0; k < $urandom_range(1, 2); k++)
                s = $sformatf("%s%c", s, ws[$urandom_range(0, 3)]);
        end
        return {s, "."};
    endfunction

    task automatic test_random();
        logic [31:0] sum;
        for (int r = 0; r < 8; r++) begin
            play(rand_stream(), 1'b1);
            n_checks++;
            if (got_m.size() !== exp_m.size()) begin
                n_fail++;
                $display("FAIL rand%0d_nwrites: got %0d required %0d", r, got_m.size(), exp_m.size());
            end
            for (int i = 0; i < exp_m.size() && i < got_m.size(); i++) begin
                n_checks++;
                if (got_m[i] !== {32'(4 * i), exp_m[i]}) begin
                    n_fail++;
                    $display("FAIL rand%0d_write%0d: got %h required %h", r, i, got_m[i],
                             {32'(4 * i), exp_m[i]});
                end
            end
            n_checks++;
            if (ifm.load_done !== (st_m == 1) || ifm.load_error !== (st_m == 2) ||
                ifm.word_count !== 16'(exp_m.size()) || we_viol !== 0) begin
                n_fail++;
                $display("FAIL rand%0d_status: done %b err %b count %0d viol %0d required status %0d count %0d",
                         r, ifm.load_done, ifm.load_error, ifm.word_count, we_viol, st_m, exp_m.size());
            end
            sum = '0;
            foreach (exp_m[i]) sum = sum + exp_m[i];
`ifdef HEX_LOADER_CHECKSUM_EN
            n_checks++;
            if (ifm.checksum !== sum) begin
                n_fail++;
                $display("FAIL rand%0d_checksum: got %h required %h", r, ifm.checksum, sum);
            end
`endif
        end
    endtask

`ifdef HEX_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        play("FFFFFFFF 00000002.", 1'b0);
        n_checks++;
        if (ifm.checksum !== 32'h00000001) begin
            n_fail++;
            $display("FAIL checksum_sum: got %h required 00000001", ifm.checksum);
        end
        pulse_start();
        n_checks++;
        if (ifm.checksum !== 32'h0) begin
            n_fail++;
            $display("FAIL checksum_clear: got %h required 00000000", ifm.checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_truncated();
        test_overflow();
        test_reset_mid();
        test_restart();
        test_random();
`ifdef HEX_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
